freq_meter_ctrl: RTL and testbench



---
 rtl/freq_meter_ctrl_if.sv | 24 ++
 rtl/freq_meter_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_freq_meter_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_meter_ctrl_if.sv
// Control and result bundle between freq_meter_ctrl (slave) and the result consumer (master).
interface freq_meter_ctrl_if #(
   parameter int unsigned CNT_WIDTH = 32
) ();
   logic                 meas_en;
   logic                 result_ack;
   logic                 result_valid;
   logic [CNT_WIDTH-1:0] fx_cnt;
   logic [CNT_WIDTH-1:0] ref_cnt;
   logic                 err_timeout;
   logic                 err_ovf;
   logic                 gate_open;
   logic                 busy;

   modport master (
      output meas_en, result_ack,
      input  result_valid, fx_cnt, ref_cnt, err_timeout, err_ovf, gate_open, busy
   );

   modport slave (
      input  meas_en, result_ack,
      output result_valid, fx_cnt, ref_cnt, err_timeout, err_ovf, gate_open, busy
   );
endinterface

// File: rtl/freq_meter_ctrl.sv
// Equal-precision frequency meter controller: fx-aligned gate, fx/ref counting, valid/ack result.
// Optional macro FREQ_CTRL_GLITCH_FILTER_EN rejects fx high/low phases shorter than 2 sys_clk cycles.
module freq_meter_ctrl #(
   parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
   parameter int unsigned GATE_CYCLES    = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   input  logic               fx_in,
   freq_meter_ctrl_if.slave   bus
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned GT_W = $clog2(GATE_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   // The opening-edge cycle is part of the gate, so MEASURE itself lasts GATE_CYCLES-1 cycles.
   localparam logic [GT_W-1:0] GATE_LAST = GT_W'(GATE_CYCLES - 2);

   if (GATE_CYCLES < 2 || TIMEOUT_CYCLES < 2 || CNT_WIDTH < 2 || CLK_FREQ_HZ == 0) begin : g_bad_params
      $error("freq_meter_ctrl: invalid parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_OPEN  = 3'd1,
      S_MEASURE    = 3'd2,
      S_WAIT_CLOSE = 3'd3,
      S_DONE       = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic                 sync1_q, sync2_q, hist_q;
   logic                 fx_edge_s;
   logic [TO_W-1:0]      to_timer_q, to_timer_d;
   logic [GT_W-1:0]      gate_timer_q, gate_timer_d;
   logic [CNT_WIDTH-1:0] work_fx_q, work_fx_d, work_ref_q, work_ref_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0] fx_cnt_q, fx_cnt_d, ref_cnt_q, ref_cnt_d;
   logic                 err_timeout_q, err_timeout_d, err_ovf_q, err_ovf_d;
   logic                 result_valid_q, result_valid_d;
   logic                 gate_open_q, gate_open_d, busy_q, busy_d;
   logic [CNT_WIDTH:0]   fx_inc_s, ref_inc_s;
   logic                 ovf_next_s;

   // Returns {increment_lost, value}; the value sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
      if (!en) begin
         return {1'b0, v};
      end else if (&v) begin
         return {1'b1, v};
      end else begin
         return {1'b0, v + {{(CNT_WIDTH-1){1'b0}}, 1'b1}};
      end
   endfunction

   // fx_in synchroniser plus history flop for rising-edge detection.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= fx_in;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

`ifdef FREQ_CTRL_GLITCH_FILTER_EN
   logic hist2_q, hist3_q, edge_q;

   // Accept an edge only after two low cycles followed by two high cycles.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         hist2_q <= 1'b0;
         hist3_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         hist2_q <= hist_q;
         hist3_q <= hist2_q;
         edge_q  <= sync2_q & hist_q & ~hist2_q & ~hist3_q;
      end
   end

   assign fx_edge_s = edge_q;
`else
   assign fx_edge_s = sync2_q & ~hist_q;
`endif

   assign fx_inc_s   = sat_inc(work_fx_q, fx_edge_s);
   assign ref_inc_s  = sat_inc(work_ref_q, 1'b1);
   assign ovf_next_s = ovf_q | fx_inc_s[CNT_WIDTH] | ref_inc_s[CNT_WIDTH];

   // Next-state and datapath control.
   always_comb begin
      state_d        = state_q;
      to_timer_d     = to_timer_q;
      gate_timer_d   = gate_timer_q;
      work_fx_d      = work_fx_q;
      work_ref_d     = work_ref_q;
      ovf_d          = ovf_q;
      fx_cnt_d       = fx_cnt_q;
      ref_cnt_d      = ref_cnt_q;
      err_timeout_d  = err_timeout_q;
      err_ovf_d      = err_ovf_q;
      result_valid_d = result_valid_q;

      case (state_q)
         S_IDLE: begin
            to_timer_d = '0;
            ovf_d      = 1'b0;
            work_fx_d  = '0;
            work_ref_d = '0;
            if (bus.meas_en) begin
               state_d = S_WAIT_OPEN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_OPEN: begin
            if (!bus.meas_en) begin
               state_d = S_IDLE;
            end else if (fx_edge_s) begin
               state_d      = S_MEASURE;
               work_fx_d    = '0;
               work_ref_d   = '0;
               gate_timer_d = '0;
            end else if (to_timer_q == TO_LAST) begin
               state_d       = S_DONE;
               fx_cnt_d      = '0;
               ref_cnt_d     = '0;
               err_timeout_d = 1'b1;
               err_ovf_d     = 1'b0;
            end else begin
               to_timer_d = to_timer_q + TO_W'(1'b1);
            end
         end
         S_MEASURE: begin
            if (!bus.meas_en) begin
               state_d = S_IDLE;
            end else begin
               work_fx_d    = fx_inc_s[CNT_WIDTH-1:0];
               work_ref_d   = ref_inc_s[CNT_WIDTH-1:0];
               ovf_d        = ovf_next_s;
               gate_timer_d = gate_timer_q + GT_W'(1'b1);
               if (gate_timer_q == GATE_LAST) begin
                  state_d    = S_WAIT_CLOSE;
                  to_timer_d = '0;
               end else begin
                  state_d = S_MEASURE;
               end
            end
         end
         S_WAIT_CLOSE: begin
            if (!bus.meas_en) begin
               state_d = S_IDLE;
            end else begin
               work_fx_d  = fx_inc_s[CNT_WIDTH-1:0];
               work_ref_d = ref_inc_s[CNT_WIDTH-1:0];
               ovf_d      = ovf_next_s;
               if (fx_edge_s || (to_timer_q == TO_LAST)) begin
                  state_d       = S_DONE;
                  fx_cnt_d      = fx_inc_s[CNT_WIDTH-1:0];
                  ref_cnt_d     = ref_inc_s[CNT_WIDTH-1:0];
                  err_timeout_d = ~fx_edge_s;
                  err_ovf_d     = ovf_next_s;
               end else begin
                  to_timer_d = to_timer_q + TO_W'(1'b1);
               end
            end
         end
         S_DONE: begin
            if (result_valid_q && bus.result_ack) begin
               result_valid_d = 1'b0;
               state_d        = S_IDLE;
            end else begin
               result_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      gate_open_d = (state_d == S_MEASURE) || (state_d == S_WAIT_CLOSE);
      busy_d      = (state_d != S_IDLE);
   end

   // State, working counters and registered outputs.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         to_timer_q     <= '0;
         gate_timer_q   <= '0;
         work_fx_q      <= '0;
         work_ref_q     <= '0;
         ovf_q          <= 1'b0;
         fx_cnt_q       <= '0;
         ref_cnt_q      <= '0;
         err_timeout_q  <= 1'b0;
         err_ovf_q      <= 1'b0;
         result_valid_q <= 1'b0;
         gate_open_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         to_timer_q     <= to_timer_d;
         gate_timer_q   <= gate_timer_d;
         work_fx_q      <= work_fx_d;
         work_ref_q     <= work_ref_d;
         ovf_q          <= ovf_d;
         fx_cnt_q       <= fx_cnt_d;
         ref_cnt_q      <= ref_cnt_d;
         err_timeout_q  <= err_timeout_d;
         err_ovf_q      <= err_ovf_d;
         result_valid_q <= result_valid_d;
         gate_open_q    <= gate_open_d;
         busy_q         <= busy_d;
      end
   end

   assign bus.result_valid = result_valid_q;
   assign bus.fx_cnt       = fx_cnt_q;
   assign bus.ref_cnt      = ref_cnt_q;
   assign bus.err_timeout  = err_timeout_q;
   assign bus.err_ovf      = err_ovf_q;
   assign bus.gate_open    = gate_open_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Self-checking bench for freq_meter_ctrl: periodic fx stimulus against an edge-counting reference model.
module tb_freq_meter_ctrl;
   localparam int GATE_A = 150;
   localparam int GATE_B = 600;
   localparam int TO     = 1000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic fx    = 1'b0;

   int checks = 0;
   int errors = 0;
   int fx_per = 10;
   int fx_hi  = 5;
   bit fx_run = 1'b0;
   longint prev_fx  = 0;
   longint prev_ref = 0;

   freq_meter_ctrl_if #(.CNT_WIDTH(32)) bus_a ();
   freq_meter_ctrl_if #(.CNT_WIDTH(8))  bus_b ();

   freq_meter_ctrl #(
      .CLK_FREQ_HZ(50_000_000), .GATE_CYCLES(GATE_A), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(32)
   ) dut_a (.sys_clk(clk), .rst_n(rst_n), .fx_in(fx), .bus(bus_a));

   freq_meter_ctrl #(
      .CLK_FREQ_HZ(50_000_000), .GATE_CYCLES(GATE_B), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)
   ) dut_b (.sys_clk(clk), .rst_n(rst_n), .fx_in(fx), .bus(bus_b));

   always #5 clk = ~clk;

   // fx waveform: period fx_per cycles, high for fx_hi cycles, starting high when enabled.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(negedge clk);
         if (fx_run) begin
            fx = (ph < fx_hi);
            ph = (ph + 1) % fx_per;
         end else begin
            fx = 1'b0;
            ph = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fx(input int per, input int hi);
      fx_run = 1'b0;
      repeat (6) tick();
      fx_per = per;
      fx_hi  = hi;
      fx_run = 1'b1;
   endtask

   // Gate opens on an fx edge and closes on the first fx edge at least GATE cycles later.
   function automatic void model(input int per, input int gate, input int width,
                                 output longint fx_e, output longint ref_e, output bit ovf_e);
      longint n, span, maxv;
      n     = (gate + per - 1) / per;
      span  = n * per;
      maxv  = (64'd1 << width) - 1;
      ovf_e = (span > maxv) || (n > maxv);
      fx_e  = (n > maxv) ? maxv : n;
      ref_e = (span > maxv) ? maxv : span;
   endfunction

   task automatic wait_valid_a(input int budget, output int cyc, output int gcyc, output bit ok);
      cyc  = 0;
      gcyc = 0;
      ok   = 1'b0;
      while (cyc < budget && !ok) begin
         tick();
         cyc++;
         if (bus_a.gate_open) gcyc++;
         if (bus_a.result_valid) ok = 1'b1;
      end
   endtask

   task automatic wait_valid_b(input int budget, output bit ok);
      int cyc;
      cyc = 0;
      ok  = 1'b0;
      while (cyc < budget && !ok) begin
         tick();
         cyc++;
         if (bus_b.result_valid) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      bus_a.meas_en = 1'b0; bus_a.result_ack = 1'b0;
      bus_b.meas_en = 1'b0; bus_b.result_ack = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({bus_a.result_valid, bus_a.err_timeout, bus_a.err_ovf, bus_a.gate_open, bus_a.busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags_a got %b want 00000",
                  {bus_a.result_valid, bus_a.err_timeout, bus_a.err_ovf, bus_a.gate_open, bus_a.busy});
      end
      checks++;
      if (bus_a.fx_cnt !== 32'd0 || bus_a.ref_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_counts_a got %0d/%0d want 0/0", bus_a.fx_cnt, bus_a.ref_cnt);
      end
      checks++;
      if ({bus_b.result_valid, bus_b.busy, bus_b.gate_open} !== 3'b0 || bus_b.fx_cnt !== 8'd0 || bus_b.ref_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_b got valid=%b busy=%b cnt=%0d/%0d want all 0",
                  bus_b.result_valid, bus_b.busy, bus_b.fx_cnt, bus_b.ref_cnt);
      end
      rst_n = 1'b1;
      tick();
   endtask

   // One measurement on dut_a; meas_en is left high and the result acknowledged.
   task automatic measure_a(input int per, input string name);
      longint fe, re;
      bit oe, ok;
      int cyc, gcyc;
      model(per, GATE_A, 32, fe, re, oe);
      wait_valid_a(GATE_A + 3 * per + 50, cyc, gcyc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_valid got none in %0d cycles want result_valid", name, cyc);
      end else begin
         checks++;
         if (bus_a.fx_cnt !== fe[31:0] || bus_a.ref_cnt !== re[31:0]) begin
            errors++;
            $display("FAIL %s_counts got fx=%0d ref=%0d want fx=%0d ref=%0d",
                     name, bus_a.fx_cnt, bus_a.ref_cnt, fe, re);
         end
         checks++;
         if (bus_a.err_timeout !== 1'b0 || bus_a.err_ovf !== oe || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_flags got to=%b ovf=%b busy=%b want 0 %b 1",
                     name, bus_a.err_timeout, bus_a.err_ovf, bus_a.busy, oe);
         end
         checks++;
         if (gcyc !== int'(re)) begin
            errors++;
            $display("FAIL %s_gate_len got %0d want %0d", name, gcyc, re);
         end
      end
      bus_a.result_ack = 1'b1;
      tick();
      bus_a.result_ack = 1'b0;
      checks++;
      if (bus_a.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_ack got valid=%b want 0", name, bus_a.result_valid);
      end
      prev_fx  = fe;
      prev_ref = re;
   endtask

   task automatic test_measure(input int per, input int hi, input string name);
      bus_a.meas_en = 1'b0;
      set_fx(per, hi);
      repeat (2) tick();
      bus_a.meas_en = 1'b1;
      measure_a(per, name);
      bus_a.meas_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      bus_a.meas_en = 1'b0;
      set_fx(100, 50);
      repeat (2) tick();
      bus_a.meas_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         measure_a(100, "b2b");
         // Stray ack with no result pending must not disturb the next run.
         bus_a.result_ack = 1'b1;
         tick();
         bus_a.result_ack = 1'b0;
         checks++;
         if (bus_a.busy !== 1'b1 || bus_a.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rearm got busy=%b valid=%b want 1 0", bus_a.busy, bus_a.result_valid);
         end
      end
      bus_a.meas_en = 1'b0;
   endtask

   task automatic test_abort();
      int c;
      bus_a.meas_en = 1'b0;
      set_fx(7, 3);
      repeat (2) tick();
      bus_a.meas_en = 1'b1;
      c = 0;
      while (c < 100 && bus_a.gate_open !== 1'b1) begin
         tick();
         c++;
      end
      checks++;
      if (bus_a.gate_open !== 1'b1) begin
         errors++;
         $display("FAIL abort_open got gate_open=%b want 1", bus_a.gate_open);
      end
      repeat (39) tick();
      bus_a.meas_en = 1'b0;
      tick();
      checks++;
      if (bus_a.busy !== 1'b0 || bus_a.gate_open !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got busy=%b gate=%b want 0 0", bus_a.busy, bus_a.gate_open);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (bus_a.result_valid !== 1'b0 || bus_a.fx_cnt !== prev_fx[31:0] || bus_a.ref_cnt !== prev_ref[31:0]) begin
            errors++;
            $display("FAIL abort_hold got valid=%b fx=%0d ref=%0d want 0 %0d %0d",
                     bus_a.result_valid, bus_a.fx_cnt, bus_a.ref_cnt, prev_fx, prev_ref);
         end
      end
   endtask

   task automatic test_timeout();
      int cyc, gcyc;
      bit ok;
      bus_a.meas_en = 1'b0;
      fx_run = 1'b0;
      repeat (6) tick();
      bus_a.meas_en = 1'b1;
      wait_valid_a(TO + 100, cyc, gcyc, ok);
      checks++;
      if (!ok || cyc < TO || cyc > TO + 10) begin
         errors++;
         $display("FAIL timeout_latency got ok=%b cycles=%0d want %0d..%0d", ok, cyc, TO, TO + 10);
      end
      checks++;
      if (bus_a.err_timeout !== 1'b1 || bus_a.err_ovf !== 1'b0 || bus_a.fx_cnt !== 32'd0
          || bus_a.ref_cnt !== 32'd0 || gcyc !== 0) begin
         errors++;
         $display("FAIL timeout_result got to=%b ovf=%b fx=%0d ref=%0d gate=%0d want 1 0 0 0 0",
                  bus_a.err_timeout, bus_a.err_ovf, bus_a.fx_cnt, bus_a.ref_cnt, gcyc);
      end
      bus_a.result_ack = 1'b1;
      tick();
      bus_a.result_ack = 1'b0;
      bus_a.meas_en = 1'b0;
      prev_fx  = 0;
      prev_ref = 0;
   endtask

   task automatic test_ack_hold();
      longint fe, re;
      bit oe, ok;
      int cyc, gcyc;
      bus_a.meas_en = 1'b0;
      set_fx(10, 5);
      repeat (2) tick();
      bus_a.meas_en = 1'b1;
      model(10, GATE_A, 32, fe, re, oe);
      wait_valid_a(GATE_A + 100, cyc, gcyc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL hold_valid got none want result_valid");
      end
      for (int i = 0; i < 50; i++) begin
         tick();
         checks++;
         if (bus_a.result_valid !== 1'b1 || bus_a.busy !== 1'b1 || bus_a.gate_open !== 1'b0
             || bus_a.fx_cnt !== fe[31:0] || bus_a.ref_cnt !== re[31:0]) begin
            errors++;
            $display("FAIL hold_stable cyc=%0d got valid=%b busy=%b gate=%b fx=%0d ref=%0d want 1 1 0 %0d %0d",
                     i, bus_a.result_valid, bus_a.busy, bus_a.gate_open, bus_a.fx_cnt, bus_a.ref_cnt, fe, re);
         end
      end
      bus_a.result_ack = 1'b1;
      tick();
      bus_a.result_ack = 1'b0;
      checks++;
      if (bus_a.result_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_ack got valid=%b busy=%b want 0 0", bus_a.result_valid, bus_a.busy);
      end
      tick();
      checks++;
      if (bus_a.busy !== 1'b1 || bus_a.gate_open !== 1'b0) begin
         errors++;
         $display("FAIL hold_reopen got busy=%b gate=%b want 1 0", bus_a.busy, bus_a.gate_open);
      end
      bus_a.meas_en = 1'b0;
      prev_fx  = fe;
      prev_ref = re;
   endtask

   task automatic test_overflow();
      longint fe, re;
      bit oe, ok;
      bus_a.meas_en = 1'b0;
      set_fx(4, 2);
      repeat (2) tick();
      model(4, GATE_B, 8, fe, re, oe);
      bus_b.meas_en = 1'b1;
      wait_valid_b(GATE_B + 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ovf_valid got none want result_valid");
      end
      checks++;
      if (bus_b.fx_cnt !== fe[7:0] || bus_b.ref_cnt !== re[7:0]) begin
         errors++;
         $display("FAIL ovf_counts got fx=%0d ref=%0d want fx=%0d ref=%0d", bus_b.fx_cnt, bus_b.ref_cnt, fe, re);
      end
      checks++;
      if (bus_b.err_ovf !== oe || bus_b.err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL ovf_flags got ovf=%b to=%b want %b 0", bus_b.err_ovf, bus_b.err_timeout, oe);
      end
      bus_b.result_ack = 1'b1;
      tick();
      bus_b.result_ack = 1'b0;
      bus_b.meas_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int cyc, gcyc;
      bit ok;
      bus_a.meas_en = 1'b0;
      set_fx(10, 5);
      repeat (2) tick();
      bus_a.meas_en = 1'b1;
      wait_valid_a(GATE_A + 100, cyc, gcyc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rstmid_valid got none want result_valid");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_a.result_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.fx_cnt !== 32'd0 || bus_a.ref_cnt !== 32'd0) begin
         errors++;
         $display("FAIL rstmid_async got valid=%b busy=%b fx=%0d ref=%0d want 0 0 0 0",
                  bus_a.result_valid, bus_a.busy, bus_a.fx_cnt, bus_a.ref_cnt);
      end
      bus_a.meas_en = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (bus_a.result_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_after got valid=%b busy=%b want 0 0", bus_a.result_valid, bus_a.busy);
      end
   endtask

   initial begin
      int per, hi;
      test_reset();
      test_measure(100, 50, "fx_div100");
      test_measure(7, 3, "fx_per7");
      for (int i = 0; i < 4; i++) begin
         per = $urandom_range(40, 4);
         hi  = $urandom_range(per - 2, 2);
         test_measure(per, hi, "fx_rand");
      end
      test_back_to_back();
      test_abort();
      test_timeout();
      test_ack_hold();
      test_overflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
